// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Constants shared by the 32x32 Wallace multiplier and the product
// accumulator: operand/product widths and the accumulator state encoding.
// ---------------------------------------------------------------------------
package mul_pkg;

    localparam int OPND_W = 32;            // multiplier operand width
    localparam int PROD_W = 2 * OPND_W;    // multiplier product width (64)

    // Accumulator FSM state encoding
    localparam logic [1:0] S_IDLE  = 2'd0; // no beats taken yet
    localparam logic [1:0] S_ACCUM = 2'd1; // at least one beat taken
    localparam logic [1:0] S_HOLD  = 2'd2; // result presented, waiting for consumer

endpackage : mul_pkg

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
// Accumulate half of the multiply-accumulate datapath. Sums a burst of
// unsigned multiplier products (delimited by prod_last) into a wider
// accumulator and holds the registered result until the consumer takes it.
//
// Ports
//   clk         in   1       rising-edge clock
//   rst         in   1       synchronous active-high reset
//   clear       in   1       synchronous abort, discards the partial sum
//   prod_valid  in   1       product beat valid
//   prod_ready  out  1       stage can accept a beat
//   prod_data   in   PROD_W  unsigned product
//   prod_last   in   1       final beat of burst (qualified by prod_valid)
//   acc_valid   out  1       result valid
//   acc_ready   in   1       consumer accepts result
//   acc_data    out  ACC_W   accumulated sum (running value outside HOLD)
//   acc_count   out  CNT_W   beats in burst, saturating
//   acc_ovf     out  1       sticky carry-out of the accumulator
// ---------------------------------------------------------------------------
module product_accumulator #(
    parameter int PROD_W = mul_pkg::PROD_W,
    parameter int ACC_W  = 72,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_last,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_data,
    output logic [CNT_W-1:0]  acc_count,
    output logic              acc_ovf
);

    import mul_pkg::S_IDLE;
    import mul_pkg::S_ACCUM;
    import mul_pkg::S_HOLD;

    // Beat counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    // One ACC_W+1-bit add; the top bit is the carry out of the accumulator.
    logic [ACC_W:0]   w_add;
    logic             w_beat;
    logic             w_take;

    assign w_add  = {1'b0, r_sum} + {{(ACC_W - PROD_W + 1){1'b0}}, prod_data};
    assign w_beat = prod_valid & prod_ready;
    assign w_take = acc_valid & acc_ready;

    // ---- state / accumulator registers ----
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state <= S_IDLE;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_beat) begin
                        r_sum   <= w_add[ACC_W-1:0];
                        r_ovf   <= r_ovf | w_add[ACC_W];
                        r_cnt   <= sat_inc(r_cnt);
                        r_state <= prod_last ? S_HOLD : S_ACCUM;
                    end
                end
                S_HOLD: begin
                    // No beat is accepted here (prod_ready=0), so the
                    // transfer simply returns to a zeroed IDLE.
                    if (w_take) begin
                        r_state <= S_IDLE;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sum   <= '0;
                    r_cnt   <= '0;
                    r_ovf   <= 1'b0;
                end
            endcase
        end
    end

    // ---- outputs: registers or decoded state only ----
    assign prod_ready = (r_state != S_HOLD);
    assign acc_valid  = (r_state == S_HOLD);
    assign acc_data   = r_sum;
    assign acc_count  = r_cnt;
    assign acc_ovf    = r_ovf;

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
// Scoreboarded bench for product_accumulator. Three instances cover the
// default configuration, ACC_W=64 (overflow) and CNT_W=2 (count saturation).
// Stimulus pushes expected results; per-instance monitors pop on transfer.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

    typedef struct {
        logic [71:0] d;
        logic [7:0]  c;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    // Instance A: default widths
    logic        a_clear = 0, a_valid = 0, a_last = 0, a_ready = 0;
    logic [63:0] a_data = '0;
    logic        a_prdy, a_avld, a_ovf;
    logic [71:0] a_acc;
    logic [7:0]  a_cnt;

    // Instance B: ACC_W = 64
    logic        b_clear = 0, b_valid = 0, b_last = 0, b_ready = 0;
    logic [63:0] b_data = '0;
    logic        b_prdy, b_avld, b_ovf;
    logic [63:0] b_acc;
    logic [7:0]  b_cnt;

    // Instance C: CNT_W = 2
    logic        c_clear = 0, c_valid = 0, c_last = 0, c_ready = 0;
    logic [63:0] c_data = '0;
    logic        c_prdy, c_avld, c_ovf;
    logic [71:0] c_acc;
    logic [1:0]  c_cnt;

    product_accumulator u_a (
        .clk(clk), .rst(rst), .clear(a_clear),
        .prod_valid(a_valid), .prod_ready(a_prdy), .prod_data(a_data), .prod_last(a_last),
        .acc_valid(a_avld), .acc_ready(a_ready), .acc_data(a_acc), .acc_count(a_cnt), .acc_ovf(a_ovf)
    );

    product_accumulator #(.ACC_W(64)) u_b (
        .clk(clk), .rst(rst), .clear(b_clear),
        .prod_valid(b_valid), .prod_ready(b_prdy), .prod_data(b_data), .prod_last(b_last),
        .acc_valid(b_avld), .acc_ready(b_ready), .acc_data(b_acc), .acc_count(b_cnt), .acc_ovf(b_ovf)
    );

    product_accumulator #(.CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .clear(c_clear),
        .prod_valid(c_valid), .prod_ready(c_prdy), .prod_data(c_data), .prod_last(c_last),
        .acc_valid(c_avld), .acc_ready(c_ready), .acc_data(c_acc), .acc_count(c_cnt), .acc_ovf(c_ovf)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_res(input string who, input logic [71:0] d, input logic [7:0] c,
                           input logic o, input exp_t e);
        chk({who, "_data"},  d, e.d);
        chk({who, "_count"}, {64'd0, c}, {64'd0, e.c});
        chk({who, "_ovf"},   {71'd0, o}, {71'd0, e.o});
    endtask

    // ---- monitors: compare whenever a result transfers ----
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !a_clear && a_avld && a_ready) begin
            if (qa.size() == 0) chk("a_unexpected_result", 72'd1, 72'd0);
            else begin e = qa.pop_front(); chk_res("a", a_acc, a_cnt, a_ovf, e); end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && !b_clear && b_avld && b_ready) begin
            if (qb.size() == 0) chk("b_unexpected_result", 72'd1, 72'd0);
            else begin e = qb.pop_front(); chk_res("b", {8'd0, b_acc}, b_cnt, b_ovf, e); end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && !c_clear && c_avld && c_ready) begin
            if (qc.size() == 0) chk("c_unexpected_result", 72'd1, 72'd0);
            else begin e = qc.pop_front(); chk_res("c", c_acc, {6'd0, c_cnt}, c_ovf, e); end
        end
    end

    // ---- drivers: called at posedge+1, return at the next posedge+1 ----
    task automatic a_send(input logic [63:0] d, input logic l);
        a_valid = 1; a_data = d; a_last = l;
        @(posedge clk); #1;
        a_valid = 0; a_last = 0;
    endtask

    task automatic b_send(input logic [63:0] d, input logic l);
        b_valid = 1; b_data = d; b_last = l;
        @(posedge clk); #1;
        b_valid = 0; b_last = 0;
    endtask

    task automatic c_send(input logic [63:0] d, input logic l);
        c_valid = 1; c_data = d; c_last = l;
        @(posedge clk); #1;
        c_valid = 0; c_last = 0;
    endtask

    task automatic a_take();
        a_ready = 1;
        @(posedge clk); #1;
        a_ready = 0;
        chk("a_idle_after_take", {71'd0, a_avld}, 72'd0);
    endtask

    task automatic push(ref exp_t q[$], input logic [71:0] d, input logic [7:0] c, input logic o);
        exp_t e;
        e.d = d; e.c = c; e.o = o;
        q.push_back(e);
    endtask

    // Hard bound on total run time
    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. reset
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_prod_ready", {71'd0, a_prdy}, 72'd1);
        chk("rst_acc_valid",  {71'd0, a_avld}, 72'd0);
        chk("rst_acc_data",   a_acc, 72'd0);
        chk("rst_acc_count",  {64'd0, a_cnt}, 72'd0);
        chk("rst_acc_ovf",    {71'd0, a_ovf}, 72'd0);
        @(posedge clk); #1;

        // 2. three-beat burst with a stalled consumer
        push(qa, 72'd68, 8'd3, 1'b0);
        a_send(64'd6, 0);
        a_send(64'd20, 0);
        chk("t2_running_sum", a_acc, 72'd26);
        a_send(64'd42, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", {71'd0, a_avld}, 72'd1);
            chk("t2_hold_ready", {71'd0, a_prdy}, 72'd0);
            chk("t2_hold_data",  a_acc, 72'd68);
            chk("t2_hold_count", {64'd0, a_cnt}, 72'd3);
        end
        @(posedge clk); #1;
        a_take();
        @(negedge clk);
        chk("t2_idle_data",  a_acc, 72'd0);
        chk("t2_idle_ready", {71'd0, a_prdy}, 72'd1);
        @(posedge clk); #1;

        // 3. headroom and overflow
        push(qa, 72'h1_FFFF_FFFF_FFFF_FFFE, 8'd2, 1'b0);
        a_send(64'hFFFF_FFFF_FFFF_FFFF, 0);
        a_send(64'hFFFF_FFFF_FFFF_FFFF, 1);
        a_take();
        push(qb, 72'd0, 8'd2, 1'b1);
        b_send(64'h8000_0000_0000_0000, 0);
        b_send(64'h8000_0000_0000_0000, 1);
        b_ready = 1; @(posedge clk); #1; b_ready = 0;

        // 4. clear drops the partial sum and the coincident beat
        a_send(64'd5, 0);
        a_send(64'd7, 0);
        a_clear = 1; a_valid = 1; a_data = 64'd100;
        @(posedge clk); #1;
        a_clear = 0; a_valid = 0;
        chk("t4_clear_data",  a_acc, 72'd0);
        chk("t4_clear_count", {64'd0, a_cnt}, 72'd0);
        push(qa, 72'd9, 8'd1, 1'b0);
        a_send(64'd9, 1);
        a_take();

        // 5. rst and clear while holding a result
        a_send(64'd3, 0);
        a_send(64'd4, 1);
        chk("t5_hold_data", a_acc, 72'd7);
        rst = 1; @(posedge clk); #1; rst = 0;
        chk("t5_rst_valid", {71'd0, a_avld}, 72'd0);
        chk("t5_rst_data",  a_acc, 72'd0);
        chk("t5_rst_ready", {71'd0, a_prdy}, 72'd1);
        a_send(64'd3, 0);
        a_send(64'd4, 1);
        chk("t5_hold2_valid", {71'd0, a_avld}, 72'd1);
        a_clear = 1; @(posedge clk); #1; a_clear = 0;
        chk("t5_clr_valid", {71'd0, a_avld}, 72'd0);
        chk("t5_clr_data",  a_acc, 72'd0);
        chk("t5_clr_ready", {71'd0, a_prdy}, 72'd1);

        // 6. count saturation, plain then throttled
        push(qc, 72'd5, 8'd3, 1'b0);
        for (int i = 0; i < 5; i++) c_send(64'd1, i == 4);
        c_ready = 1; @(posedge clk); #1; c_ready = 0;

        push(qc, 72'd5, 8'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 2)) begin
                c_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            c_ready = 1'($urandom_range(0, 1));
            c_send(64'd1, i == 4);
        end
        begin
            int n;
            n = 0;
            while (c_avld && n < 50) begin
                c_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                n++;
            end
            c_ready = 0;
            chk("t6_throttle_drained", {71'd0, c_avld}, 72'd0);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("qa_empty", 72'(qa.size()), 72'd0);
        chk("qb_empty", 72'(qb.size()), 72'd0);
        chk("qc_empty", 72'(qc.size()), 72'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_product_accumulator
